// File: rtl/uart_tx_sched_if.sv
// Requester/TX bundle for uart_tx_sched: per-requester req/ack with byte data,
// plus the serial line and status back to the board logic.
interface uart_tx_sched_if #(
   parameter int unsigned NREQ = 4
);
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   ack;
   logic              tx;
   logic              busy;
   logic [1:0]        grant_id;

   modport master (output req, req_data, input  ack, tx, busy, grant_id);
   modport slave  (input  req, req_data, output ack, tx, busy, grant_id);
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler + 8N1/8N2 UART serializer sharing one TX line.
// Define UART_PARITY_EN to insert an even-parity bit after data bit 7 (8E1/8E2).
module uart_tx_sched #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned BAUD_DIV  = 347,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_sched_if.slave bus
);
   localparam int unsigned CW = 12;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t          state_q, state_n;
   logic [CW-1:0]   baud_q, baud_n;
   logic [2:0]      bit_q, bit_n;
   logic [7:0]      sh_q, sh_n;
   logic            tx_q, tx_n;
   logic            busy_q, busy_n;
   logic [NREQ-1:0] ack_q, ack_n;
   logic [1:0]      gid_q, gid_n;
   logic [1:0]      last_q, last_n;
   logic            par_q, par_n;

   logic [3:0]      req4;
   logic [31:0]     data32;
   logic [1:0]      cand, win;
   logic            found;
   logic [7:0]      win_byte;
   logic            wrap;
   logic [CW-1:0]   baud_inc;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         ack_q   <= '0;
         gid_q   <= '0;
         last_q  <= 2'(NREQ-1);
         par_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         baud_q  <= baud_n;
         bit_q   <= bit_n;
         sh_q    <= sh_n;
         tx_q    <= tx_n;
         busy_q  <= busy_n;
         ack_q   <= ack_n;
         gid_q   <= gid_n;
         last_q  <= last_n;
         par_q   <= par_n;
      end
   end

   // Next state, arbitration and serializer
   always_comb begin
      state_n  = state_q;
      baud_n   = baud_q;
      bit_n    = bit_q;
      sh_n     = sh_q;
      tx_n     = tx_q;
      busy_n   = busy_q;
      ack_n    = '0;
      gid_n    = gid_q;
      last_n   = last_q;
      par_n    = par_q;
      found    = 1'b0;
      cand     = '0;
      win      = last_q;
      win_byte = '0;

      // Indices >= NREQ are zero-padded and never win, so a mod-4 search
      // starting after last_q yields the same order as a mod-NREQ one.
      req4   = 4'(bus.req);
      data32 = 32'(bus.req_data);

      wrap     = (baud_q == CW'(BAUD_DIV-1));
      baud_inc = wrap ? '0 : baud_q + CW'(1);

      for (int k = 1; k <= 4; k++) begin
         cand = last_q + 2'(k);
         if (!found && req4[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end

      case (win)
         2'd0:    win_byte = data32[7:0];
         2'd1:    win_byte = data32[15:8];
         2'd2:    win_byte = data32[23:16];
         default: win_byte = data32[31:24];
      endcase

      case (state_q)
         S_IDLE: begin
            tx_n   = 1'b1;
            busy_n = 1'b0;
            if (found) begin
               state_n = S_START;
               ack_n   = NREQ'(4'b0001 << win);
               gid_n   = win;
               last_n  = win;
               busy_n  = 1'b1;
               tx_n    = 1'b0;
               baud_n  = '0;
               bit_n   = '0;
               sh_n    = win_byte;
               par_n   = ^win_byte;
            end
         end
         S_START: begin
            baud_n = baud_inc;
            if (wrap) begin
               state_n = S_DATA;
               tx_n    = sh_q[0];
               bit_n   = '0;
            end
         end
         S_DATA: begin
            baud_n = baud_inc;
            if (wrap) begin
               if (bit_q == 3'd7) begin
                  bit_n = '0;
`ifdef UART_PARITY_EN
                  state_n = S_PARITY;
                  tx_n    = par_q;
`else
                  state_n = S_STOP;
                  tx_n    = 1'b1;
`endif
               end else begin
                  bit_n = bit_q + 3'd1;
                  sh_n  = {1'b0, sh_q[7:1]};
                  tx_n  = sh_q[1];
               end
            end
         end
`ifdef UART_PARITY_EN
         S_PARITY: begin
            baud_n = baud_inc;
            if (wrap) begin
               state_n = S_STOP;
               tx_n    = 1'b1;
               bit_n   = '0;
            end
         end
`endif
         S_STOP: begin
            baud_n = baud_inc;
            tx_n   = 1'b1;
            if (wrap) begin
               if (bit_q == 3'(STOP_BITS-1)) begin
                  state_n = S_IDLE;
                  busy_n  = 1'b0;
                  bit_n   = '0;
               end else begin
                  bit_n = bit_q + 3'd1;
               end
            end
         end
         default: begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
         end
      endcase
   end

   assign bus.ack      = ack_q;
   assign bus.tx       = tx_q;
   assign bus.busy     = busy_q;
   assign bus.grant_id = gid_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched (BAUD_DIV=4, STOP_BITS=1, NREQ=4).
// Honours UART_PARITY_EN for frame length and the parity-bit test.
module tb_uart_tx_sched;
   localparam int unsigned NREQ = 4;
   localparam int unsigned BAUD = 4;
`ifdef UART_PARITY_EN
   localparam int FRAME = 44;
`else
   localparam int FRAME = 40;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_sched_if #(.NREQ(NREQ)) bus ();

   uart_tx_sched #(.NREQ(NREQ), .BAUD_DIV(BAUD), .STOP_BITS(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Expected tx level at offset o from the start-bit cycle of byte b.
   function automatic logic exp_tx(input logic [7:0] b, input int o);
      logic [7:0] t;
      if (o < 4) return 1'b0;
      if (o < 36) begin
         t = b >> ((o - 4) / 4);
         return t[0];
      end
`ifdef UART_PARITY_EN
      if (o < 40) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.req      = '0;
      bus.req_data = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      bus.req_data = 32'h0000_3300;
      bus.req      = 4'b0100;
      tick();
      bus.req = '0;
      tick();
      tick();
      rst     = 1'b1;
      bus.req = 4'b1111;
      tick();
      checks++;
      if (bus.tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b want=1", bus.tx); end
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      checks++;
      if (bus.ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b want=0000", bus.ack); end
      checks++;
      if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL reset_gid got=%0d want=0", bus.grant_id); end
      rst     = 1'b0;
      bus.req = '0;
   endtask

   task automatic test_single();
      do_reset();
      bus.req_data = 32'h0000_00A5;
      bus.req      = 4'b0001;
      tick();
      checks++;
      if (bus.ack !== 4'b0001) begin failures++; $display("FAIL single_ack got=%b want=0001", bus.ack); end
      checks++;
      if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL single_gid got=%0d want=0", bus.grant_id); end
      bus.req = '0;
      for (int o = 0; o < FRAME; o++) begin
         checks++;
         if (bus.tx !== exp_tx(8'hA5, o)) begin
            failures++;
            $display("FAIL single_tx off=%0d got=%b want=%b", o, bus.tx, exp_tx(8'hA5, o));
         end
         checks++;
         if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy off=%0d got=%b want=1", o, bus.busy); end
         if (o == 1) begin
            checks++;
            if (bus.ack !== 4'b0000) begin failures++; $display("FAIL single_ack_pulse got=%b want=0000", bus.ack); end
         end
         tick();
      end
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b want=0", bus.busy); end
      checks++;
      if (bus.tx !== 1'b1) begin failures++; $display("FAIL single_tx_end got=%b want=1", bus.tx); end
   endtask

   task automatic test_round_robin();
      int         prev;
      int         n;
      logic [7:0] byte_v;
      logic [3:0] exp_ack;
      logic [1:0] exp_id;
      logic [7:0] exp_byte;
      do_reset();
      bus.req_data = 32'h4433_2211;
      bus.req      = 4'b1111;
      prev         = -1;
      tick();
      for (int f = 0; f < 5; f++) begin
         n = 0;
         while (bus.ack === 4'b0000 && n < 100) begin tick(); n++; end
         if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL rr_timeout frame=%0d got=no_ack want=ack", f);
            bus.req = '0;
            return;
         end
         exp_id   = 2'(f % 4);
         exp_ack  = 4'b0001 << exp_id;
         exp_byte = 8'(8'h11 * (f % 4 + 1));
         checks++;
         if (bus.ack !== exp_ack) begin failures++; $display("FAIL rr_ack frame=%0d got=%b want=%b", f, bus.ack, exp_ack); end
         checks++;
         if (bus.grant_id !== exp_id) begin failures++; $display("FAIL rr_gid frame=%0d got=%0d want=%0d", f, bus.grant_id, exp_id); end
         if (prev >= 0) begin
            checks++;
            if (cyc - prev != FRAME + 1) begin
               failures++;
               $display("FAIL rr_period frame=%0d got=%0d want=%0d", f, cyc - prev, FRAME + 1);
            end
         end
         prev   = cyc;
         byte_v = '0;
         for (int c = 1; c <= FRAME; c++) begin
            tick();
            if (c >= 6 && c <= 34 && (c - 6) % 4 == 0) byte_v = {bus.tx, byte_v[7:1]};
         end
         checks++;
         if (byte_v !== exp_byte) begin failures++; $display("FAIL rr_byte frame=%0d got=%h want=%h", f, byte_v, exp_byte); end
      end
      bus.req = '0;
   endtask

   task automatic test_withdraw();
      int bad_ack, bad_tx, bad_busy;
      bad_ack  = 0;
      bad_tx   = 0;
      bad_busy = 0;
      do_reset();
      bus.req_data = 32'h0077_003C;
      bus.req      = 4'b0001;
      tick();
      bus.req = '0;
      for (int o = 1; o <= FRAME + 20; o++) begin
         tick();
         if (o == 10) bus.req[2] = 1'b1;
         if (o == 30) bus.req[2] = 1'b0;
         if (bus.ack !== 4'b0000) bad_ack++;
         if (o >= FRAME - 4 && bus.tx !== 1'b1) bad_tx++;
         if (o >= FRAME && bus.busy !== 1'b0) bad_busy++;
      end
      checks++;
      if (bad_ack != 0) begin failures++; $display("FAIL withdraw_ack got=%0d want=0", bad_ack); end
      checks++;
      if (bad_tx != 0) begin failures++; $display("FAIL withdraw_tx got=%0d want=0", bad_tx); end
      checks++;
      if (bad_busy != 0) begin failures++; $display("FAIL withdraw_busy got=%0d want=0", bad_busy); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] byte_v;
      do_reset();
      bus.req_data = 32'h0000_0000;
      bus.req      = 4'b0001;
      tick();
      bus.req = '0;
      for (int o = 1; o <= 13; o++) tick();
      checks++;
      if (bus.tx !== 1'b0) begin failures++; $display("FAIL mid_pre_tx got=%b want=0", bus.tx); end
      rst = 1'b1;
      tick();
      checks++;
      if (bus.tx !== 1'b1) begin failures++; $display("FAIL mid_tx got=%b want=1", bus.tx); end
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b want=0", bus.busy); end
      checks++;
      if (bus.ack !== 4'b0000) begin failures++; $display("FAIL mid_ack got=%b want=0000", bus.ack); end
      rst          = 1'b0;
      bus.req_data = 32'h5A00_0000;
      bus.req      = 4'b1000;
      tick();
      checks++;
      if (bus.ack !== 4'b1000) begin failures++; $display("FAIL mid_ack3 got=%b want=1000", bus.ack); end
      checks++;
      if (bus.grant_id !== 2'd3) begin failures++; $display("FAIL mid_gid got=%0d want=3", bus.grant_id); end
      bus.req = '0;
      byte_v  = '0;
      for (int c = 1; c <= FRAME; c++) begin
         tick();
         if (c >= 6 && c <= 34 && (c - 6) % 4 == 0) byte_v = {bus.tx, byte_v[7:1]};
         if (c == FRAME - 1) begin
            checks++;
            if (bus.tx !== 1'b1 || bus.busy !== 1'b1) begin
               failures++;
               $display("FAIL mid_stop got=tx%b/busy%b want=tx1/busy1", bus.tx, bus.busy);
            end
         end
      end
      checks++;
      if (byte_v !== 8'h5A) begin failures++; $display("FAIL mid_byte got=%h want=5a", byte_v); end
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_end_busy got=%b want=0", bus.busy); end
   endtask

   task automatic test_priority();
      int n;
      do_reset();
      bus.req_data = 32'h4433_2211;
      bus.req      = 4'b0010;
      tick();
      checks++;
      if (bus.ack !== 4'b0010) begin failures++; $display("FAIL prio_first got=%b want=0010", bus.ack); end
      bus.req = 4'b1010;
      for (int g = 0; g < 2; g++) begin
         tick();
         n = 0;
         while (bus.ack === 4'b0000 && n < 100) begin tick(); n++; end
         checks++;
         if (g == 0 && bus.ack !== 4'b1000) begin failures++; $display("FAIL prio_ack3 got=%b want=1000", bus.ack); end
         else if (g == 1 && bus.ack !== 4'b0010) begin failures++; $display("FAIL prio_ack1 got=%b want=0010", bus.ack); end
         checks++;
         if (g == 0 && bus.grant_id !== 2'd3) begin failures++; $display("FAIL prio_gid3 got=%0d want=3", bus.grant_id); end
         else if (g == 1 && bus.grant_id !== 2'd1) begin failures++; $display("FAIL prio_gid1 got=%0d want=1", bus.grant_id); end
         bus.req = 4'b0010;
      end
      bus.req = '0;
   endtask

`ifdef UART_PARITY_EN
   task automatic test_parity();
      logic [7:0] bytes [2];
      bytes[0] = 8'h07;
      bytes[1] = 8'h03;
      for (int i = 0; i < 2; i++) begin
         do_reset();
         bus.req_data = 32'(bytes[i]);
         bus.req      = 4'b0001;
         tick();
         bus.req = '0;
         for (int o = 1; o <= 44; o++) begin
            tick();
            if (o == 37) begin
               checks++;
               if (bus.tx !== (i == 0 ? 1'b1 : 1'b0)) begin
                  failures++;
                  $display("FAIL parity_bit byte=%h got=%b want=%b", bytes[i], bus.tx, (i == 0 ? 1'b1 : 1'b0));
               end
            end
            if (o == 41) begin
               checks++;
               if (bus.tx !== 1'b1) begin failures++; $display("FAIL parity_stop got=%b want=1", bus.tx); end
            end
            if (o == 43) begin
               checks++;
               if (bus.busy !== 1'b1) begin failures++; $display("FAIL parity_busy43 got=%b want=1", bus.busy); end
            end
            if (o == 44) begin
               checks++;
               if (bus.busy !== 1'b0) begin failures++; $display("FAIL parity_busy44 got=%b want=0", bus.busy); end
            end
         end
      end
   endtask
`endif

   initial begin
      rst          = 1'b1;
      bus.req      = '0;
      bus.req_data = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_withdraw();
      test_reset_mid();
      test_priority();
`ifdef UART_PARITY_EN
      test_parity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler and serializer that shares the single board UART TX line between several byte producers.
- Typical producers: command echo, audio-select report, status/heartbeat.
- Each requester offers one byte with a req/ack handshake. The block grants one requester, latches its byte and sends an 8N1 frame (LSB first). It then re-arbitrates.
- Sits between the command decoder/report logic and the TX pad bit (io_a_out[6]).

Parameters:
- NREQ, 4, number of requesters; legal values 2..4. grant_id is always 2 bits wide.
- BAUD_DIV, 347, clk cycles per UART bit (40 MHz / 115200). Legal range 2..4095; counter is 12 bits.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  system clock, 40 MHz
- rst  in  1  synchronous reset, active-high
- req  in  NREQ  per-requester byte request; level, held until ack
- req_data  in  8*NREQ  byte for requester i at bits [8i+7:8i]; must be stable while req[i]=1
- ack  out  NREQ  one-cycle pulse; byte of requester i accepted
- tx  out  1  UART serial output; idle high
- busy  out  1  high from grant cycle through the last stop-bit cycle
- grant_id  out  2  index of the requester currently being served; holds its value when idle

Behaviour:
- Reset values (all synchronous, take effect at the rst edge): tx=1, busy=0, ack=0, grant_id=0, state=IDLE, bit counters=0. Last-grant pointer = NREQ-1, so req[0] has highest priority after reset.
- States: IDLE -> START -> DATA (8 bits) -> [PARITY] -> STOP -> IDLE. All outputs are registered.
- IDLE, req==0: stay in IDLE with tx=1, busy=0.
- IDLE, any req bit set at edge k, registered at k+1:
  - winner = first set req[i] searching from (last+1) mod NREQ, wrapping;
  - ack[winner]=1 for exactly that one cycle;
  - byte is latched into the shift register;
  - grant_id=winner, last=winner, busy=1, tx=0 (start bit), state=START.
- START, DATA and STOP each bit lasts exactly BAUD_DIV cycles.
  - Baud counter runs 0..BAUD_DIV-1 and wraps to 0.
  - The bit counter advances on the wrap.
  - DATA sends latched bits 0..7 in order.
  - STOP holds tx=1 for STOP_BITS*BAUD_DIV cycles.
- On the last STOP cycle: busy=0, state=IDLE. Arbitration happens in the following IDLE cycle.
- Back-to-back frame period = (10 or 11 + STOP_BITS - 1)*BAUD_DIV + 1 cycles. With STOP_BITS=1 and no parity: 10*BAUD_DIV + 1.
- Requests are ignored while busy. A req that drops before it is granted is withdrawn silently: no ack, no frame.
- Requester obligations:
  - a requester that sees ack must deassert req in the cycle after ack, or change req_data for its next byte;
  - req still high with new data one cycle after ack is a new request;
  - the block does not sample req in that cycle because it is busy.
- Simultaneous requests: only one ack per arbitration. The others stay pending.
- Round-robin fairness: with all NREQ requests held continuously, grants cycle 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 frames.
- Single requester continuously requesting is granted every frame.
- rst asserted mid-frame:
  - tx returns to 1 at the next edge;
  - frame is truncated, busy=0, no ack is issued;
  - pointer = NREQ-1.
- req_data bits for indices >= NREQ do not exist. req bits are never out of range.

Optional Feature:
- UART_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) is inserted after bit 7 and lasts BAUD_DIV cycles. Frame becomes 8E1 or 8E2.
- UART_PARITY_EN undefined: no parity state; frame is 8N1 or 8N2.

Test Plan (BAUD_DIV=4, STOP_BITS=1, NREQ=4 unless noted):
- Single req[0] with data 0xA5 at cycle 10:
  - ack[0] at cycle 11 only; busy=1 cycles 11..50; tx low 11..14;
  - then data bits 1,0,1,0,0,1,0,1, 4 cycles each; tx high 47..50; busy=0 at 51.
- req=4'b1111 held with data 0x11,0x22,0x33,0x44:
  - frames go out 0x11,0x22,0x33,0x44,0x11 in that order;
  - start-bit falls 41 cycles apart; one ack per frame, in order 0,1,2,3,0.
- req[2] raised while busy and dropped before the stop bit ends: no ack[2], no extra frame, tx stays 1.
- rst pulsed at the 3rd data bit of a 0x00 frame:
  - tx=1 and busy=0 on the next edge;
  - a following req[3] of 0x5A gets a complete, correct frame with grant_id=3.
- req[1] and req[3] set in the same cycle right after a grant to 1: req[3] wins; ack[3] only.
- UART_PARITY_EN, byte 0x07: after bit 7, tx=1 (parity of three ones) for 4 cycles; frame length 44 cycles before busy=0.
